// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor.
// The master drives operands and start; the slave returns status and results.
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  ready, done, result, cout, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output ready, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full-adder cell, one bit per clock, LSB first.
// Sequencing is IDLE -> RUN (WIDTH edges) -> DONE (one-cycle done pulse) -> IDLE.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [WIDTH-1:0] result_d;
    logic [CW-1:0]    cnt_q;
    logic             mode_q, carry_q, cout_q, ovf_q, done_q, ready_q;
    logic             a_bit, b_bit, sum_d, carry_d, last_bit;

    // The single full-adder cell; subtraction inverts B here and seeds carry with 1.
    always_comb begin
        a_bit    = a_q[cnt_q];
        b_bit    = b_q[cnt_q] ^ mode_q;
        sum_d    = a_bit ^ b_bit ^ carry_q;
        carry_d  = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_res
            assign result_d[gi] = (cnt_q == CW'(gi)) ? sum_d : result_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        mode_q  <= bus.mode;
                        carry_q <= bus.mode;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= carry_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // Overflow is carry-in XOR carry-out of the sign bit.
                        cout_q  <= carry_d;
                        ovf_q   <= carry_q ^ carry_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl at WIDTH=8: expected results are
// queued when an operation is launched and compared when done pulses.
module tb_serial_addsub_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_addsub_ctrl_if #(.WIDTH(W)) bus();
    serial_addsub_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t         e;
        logic [W:0]   s;
        logic [W-1:0] nb;
        nb = ~b;
        if (!m) s = {1'b0, a} + {1'b0, b};
        else    s = {1'b0, a} + {1'b0, nb} + (W+1)'(1);
        e.r = s[W-1:0];
        e.c = s[W];
        if (!m) e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
        else    e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          input bit hammer, input string tag);
        exp_t e;
        int   edges;
        int   d0;
        wait_ready();
        bus.a = a; bus.b = b; bus.mode = m; bus.start = 1'b1;
        sb_q.push_back(model(a, b, m));
        d0 = done_cnt;
        @(posedge clk); #1;
        edges = 0;
        while (bus.done !== 1'b1 && edges < 3*W) begin
            if (hammer) begin
                bus.start = 1'b1;
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.mode = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        bus.start = 1'b0;
        chk({tag, "_lat"}, edges, W);
        e = '0;
        if (bus.done === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_res"}, {24'd0, bus.result}, {24'd0, e.r});
            chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, e.c});
            chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, e.v});
        end else begin
            chk({tag, "_done_to"}, {31'd0, bus.done}, 32'd1);
            void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, bus.ready}, 32'd1);
        chk({tag, "_res_hold"}, {24'd0, bus.result}, {24'd0, e.r});
        chk({tag, "_ndone"}, done_cnt - d0, 1);
        $display("op %s a=%02h b=%02h mode=%0d result=%02h cout=%0d ovf=%0d",
                 tag, a, b, m, bus.result, bus.cout, bus.overflow);
    endtask

    initial begin
        int d0;
        // Reset held with start asserted: reset must win.
        bus.start = 1'b1; bus.mode = 1'b0; bus.a = 8'h01; bus.b = 8'h01;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_res", {24'd0, bus.result}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, "add5a3c");
        run_op(8'h10, 8'h01, 1'b1, 1'b0, "sub1001");
        run_op(8'h00, 8'h01, 1'b1, 1'b0, "sub0001");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "addff01");
        run_op(8'h80, 8'h01, 1'b1, 1'b0, "sub8001");
        run_op(8'h37, 8'h21, 1'b1, 1'b1, "hammer");

        // Abort mid-RUN: rst sampled on the 4th RUN edge.
        wait_ready();
        bus.a = 8'h5A; bus.b = 8'h3C; bus.mode = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_res", {24'd0, bus.result}, 32'd0);
        chk("abort_cout", {31'd0, bus.cout}, 32'd0);
        chk("abort_ovf", {31'd0, bus.overflow}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        repeat (2*W) @(posedge clk);
        #1;
        chk("abort_nodone", done_cnt - d0, 0);
        $display("op abort result=%02h ready=%0d", bus.result, bus.ready);

        run_op(8'h01, 8'h02, 1'b0, 1'b0, "add0102");

        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001: The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002: The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003: The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004: The block SHALL have port start, input, 1 bit, request to begin an operation, sampled only while ready=1.
REQ-005: The block SHALL have port mode, input, 1 bit: 0 = add (A+B), 1 = subtract (A-B); sampled with start.
REQ-006: The block SHALL have ports a and b, input, WIDTH bits each, the operands; sampled with start.
REQ-007: The block SHALL have port ready, output, 1 bit, high when idle and able to accept start.
REQ-008: The block SHALL have port done, output, 1 bit, a one-cycle pulse marking result valid.
REQ-009: The block SHALL have port result, output, WIDTH bits, the sum or difference.
REQ-010: The block SHALL have port cout, output, 1 bit: add = carry out; subtract = NOT borrow (1 = no borrow).
REQ-011: The block SHALL have port overflow, output, 1 bit, two's-complement signed overflow of the operation.

Function
REQ-012: The block SHALL compute with a single 1-bit full-adder cell, one bit per clock, LSB first; no WIDTH-bit adder is permitted.
REQ-013: The cell SHALL compute sum = a_i ^ (b_i ^ mode) ^ c and c_next = (a_i & (b_i ^ mode)) | (c & (a_i ^ (b_i ^ mode))).
REQ-014: The carry register SHALL be initialised to mode on accept, so that subtraction is A + ~B + 1.
REQ-015: The FSM SHALL have states IDLE, RUN, DONE; ready = (state == IDLE).
REQ-016: IDLE -> RUN on a clock edge with start=1; a, b and mode are latched into internal registers, and the bit counter is cleared.
REQ-017: In RUN, the block SHALL process bit index = counter on each edge, store the sum bit into result, update carry, and increment the counter.
REQ-018: RUN -> DONE on the edge that processes bit WIDTH-1; there are exactly WIDTH RUN edges.
REQ-019: done SHALL be 1 only in DONE; DONE -> IDLE unconditionally on the next edge.
REQ-020: Latency: if start is sampled at edge k, done is high in the cycle following edge k+WIDTH, and ready returns high after edge k+WIDTH+1.
REQ-021: result, cout and overflow SHALL be valid when done=1 and held unchanged until the next accepted start.
REQ-022: overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-023: start while in RUN or DONE SHALL be ignored; changes to a, b and mode after accept SHALL NOT affect the operation in progress.
REQ-024: Results wrap modulo 2^WIDTH; cout and overflow carry the out-of-range information.

Reset
REQ-025: rst=1 at any edge, including mid-RUN, SHALL force IDLE; the operation is abandoned with no done pulse.
REQ-026: On that edge, result, cout, overflow, the carry register, the counter and done SHALL be cleared to 0, and ready SHALL be 1.
REQ-027: rst SHALL take priority over start in the same cycle.

Verification (WIDTH=8)
REQ-028: Add 0x5A+0x3C, mode=0: result=0x96, cout=0, overflow=1, with done exactly 8 edges after the start edge.
REQ-029: Subtract 0x10-0x01, mode=1: result=0x0F, cout=1, overflow=0.
REQ-030: Subtract 0x00-0x01, mode=1: result=0xFF, cout=0 (borrow), overflow=0.
REQ-031: Add 0xFF+0x01, mode=0: result=0x00, cout=1, overflow=0; also subtract 0x80-0x01: result=0x7F, cout=1, overflow=1.
REQ-032: Assert start with new operands on every cycle during RUN: only the first operation completes, done pulses once, and the result is unaffected.
REQ-033: Assert rst at the 4th RUN edge: all outputs read 0, ready=1, and no done pulse; a following start of 0x01+0x02 yields 0x03.
